// File: rtl/framebuffer_store.sv
// Assembles pairs of incoming bytes into rgb565 pixels and writes one full
// 2048-pixel frame into the display RAM, using the display's fetch address layout.
module framebuffer_store #(
    parameter int HIGH_BYTE_FIRST = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [10:0] ram_addr,
    output logic [15:0] ram_data_out,
    output logic        ram_write_enable,
    output logic        ram_clk_enable,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FIRST  = 3'd1;
    localparam logic [2:0] ST_SECOND = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [10:0] LAST_PIXEL = 11'd2047;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [10:0] pixel;
    logic [10:0] pixel_next;
    logic [7:0]  first_byte;
    logic [7:0]  first_byte_next;
    logic        load_write;
    logic [15:0] pixel_word;
    logic [10:0] pixel_addr;
    logic        busy_next;

    // frame_start wins over everything, including a byte arriving in the same cycle
    always_comb begin
        state_next      = state;
        pixel_next      = pixel;
        first_byte_next = first_byte;
        load_write      = 1'b0;
        if (frame_start) begin
            state_next = ST_FIRST;
            pixel_next = 11'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_FIRST: begin
                    if (rx_valid) begin
                        first_byte_next = rx_data;
                        state_next      = ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (rx_valid) begin
                        load_write = 1'b1;
                        state_next = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (pixel == LAST_PIXEL) begin
                        state_next = ST_DONE;
                    end else begin
                        pixel_next = pixel + 11'd1;
                        // a byte landing during the write is the first byte of the next pixel
                        if (rx_valid) begin
                            first_byte_next = rx_data;
                            state_next      = ST_SECOND;
                        end else begin
                            state_next = ST_FIRST;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        if (HIGH_BYTE_FIRST != 0) begin
            pixel_word = {first_byte, rx_data};
        end else begin
            pixel_word = {rx_data, first_byte};
        end
    end

    // Columns run right-to-left within each 64-pixel row; row bit 4 picks the bottom half
    assign pixel_addr = {pixel[10], pixel[9:6], ~pixel[5:0]};

    assign busy_next = (state_next == ST_FIRST) || (state_next == ST_SECOND) ||
                       (state_next == ST_WRITE);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pixel      <= 11'd0;
            first_byte <= 8'd0;
        end else begin
            state      <= state_next;
            pixel      <= pixel_next;
            first_byte <= first_byte_next;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ram_addr         <= 11'd0;
            ram_data_out     <= 16'd0;
            ram_write_enable <= 1'b0;
            ram_clk_enable   <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            if (load_write) begin
                ram_addr     <= pixel_addr;
                ram_data_out <= pixel_word;
            end
            ram_write_enable <= load_write;
            ram_clk_enable   <= load_write;
            busy             <= busy_next;
            frame_done       <= (state_next == ST_DONE);
        end
    end

endmodule

// File: doc/framebuffer_store.md
FRAMEBUFFER_STORE -- requirements
Module: framebuffer_store

Interface
REQ-001 SHALL have parameter HIGH_BYTE_FIRST, default 1, meaning that 1 takes the first byte of each pixel as rgb565[15:8] and 0 takes it as rgb565[7:0].
REQ-002 SHALL have port clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; reset is asserted while reset==0.
REQ-004 SHALL have port frame_start  input  1  one-cycle strobe that begins a new frame at pixel 0.
REQ-005 SHALL have port rx_data  input  8  incoming pixel byte.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe marking rx_data valid.
REQ-007 SHALL have port ram_addr  output  11  RAM write address.
REQ-008 SHALL have port ram_data_out  output  16  rgb565 word to write.
REQ-009 SHALL have port ram_write_enable  output  1  write strobe.
REQ-010 SHALL have port ram_clk_enable  output  1  RAM port clock enable.
REQ-011 SHALL have port busy  output  1  high from frame acceptance until the final write.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after pixel 2047 is written.

Function
REQ-013 SHALL register all outputs on the rising edge of clk_in.
REQ-014 SHALL implement the states IDLE, FIRST, SECOND, WRITE and DONE.
REQ-015 IDLE: SHALL ignore rx_valid; on frame_start, SHALL clear the pixel counter p[10:0] and go to FIRST.
REQ-016 FIRST: on rx_valid, SHALL latch rx_data into the first-byte half per HIGH_BYTE_FIRST and go to SECOND.
REQ-017 SECOND: on rx_valid, SHALL latch rx_data into the other half and go to WRITE.
REQ-018 WRITE: SHALL hold ram_write_enable=1 and ram_clk_enable=1 for exactly one cycle, with ram_addr and ram_data_out valid in that same cycle.
REQ-019 WRITE exit: if p==2047, SHALL go to DONE; otherwise SHALL increment p and go to FIRST.
REQ-020 WRITE with rx_valid=1 and p!=2047: SHALL treat the byte as the first byte of pixel p+1 and go straight to SECOND, so no byte is lost.
REQ-021 WRITE with rx_valid=1 and p==2047: SHALL discard the byte.
REQ-022 DONE: SHALL pulse frame_done for one cycle, then go to IDLE.
REQ-023 Latency: when the second byte is accepted at edge N, ram_write_enable SHALL be high in cycle N+1 only.
REQ-024 Address map: with column c=p[5:0] and row r=p[10:6], ram_addr SHALL equal {r[4], r[3:0], ~c[5:0]}; bit 10 selects the bottom half, matching the display fetch mapping.
REQ-025 ram_write_enable and ram_clk_enable SHALL be 0 in every state except WRITE.
REQ-026 busy SHALL be 1 in FIRST, SECOND and WRITE, and 0 in IDLE and DONE.
REQ-027 frame_start in any state except IDLE SHALL abort the frame: p cleared to 0, any partial pixel discarded, next state FIRST, no write in that cycle.
REQ-028 frame_start and rx_valid in the same cycle SHALL give priority to frame_start, and the byte SHALL be discarded.
REQ-029 The pixel counter SHALL never wrap inside a frame; frames end only through DONE or an abort.

Reset
REQ-030 While reset==0, the state SHALL be IDLE and p=0.
REQ-031 While reset==0, outputs SHALL be ram_addr=11'd0, ram_data_out=16'd0, ram_write_enable=0, ram_clk_enable=0, busy=0 and frame_done=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial pixel, perform no write, and require a fresh frame_start after release.
REQ-033 Release of reset SHALL take effect at the first clk_in rising edge after reset returns to 1.

Verification
REQ-034 Single pixel: frame_start, then bytes 0xF8, 0x1F with HIGH_BYTE_FIRST=1 -> one write with ram_addr=0x03F, ram_data_out=0xF81F, enable high for 1 cycle.
REQ-035 Row and half crossing: stream 64 pixels -> the 65th write has ram_addr=0x07F; pixel 1024 -> ram_addr=0x43F; pixel 2047 -> ram_addr=0x7C0.
REQ-036 Full frame: 4096 back-to-back bytes, including one arriving during each WRITE cycle -> 2048 writes, frame_done pulses once, busy falls, and a 4097th byte is ignored.
REQ-037 Abort: frame_start after 3 pixels plus 1 byte -> the partial byte is dropped and the next two bytes are written to ram_addr=0x03F.
REQ-038 Reset mid-SECOND (reset=0 for 2 cycles) -> no write occurs, all outputs read 0, and bytes sent before the next frame_start are ignored.
REQ-039 HIGH_BYTE_FIRST=0: bytes 0x1F, 0xF8 -> ram_data_out=0xF81F.
